// File: rtl/fifo_width_down_conv.sv
// Width-down-converting FIFO: one IN_W word is written per push and drained as RATIO OUT_W words.
// First-word fall-through read port, concurrent read/write, synchronous flush and write-room status.
module fifo_width_down_conv #(
   parameter int OUT_W      = 16,
   parameter int RATIO      = 2,
   parameter int DEPTH_LOG2 = 4,
   parameter int MSB_FIRST  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   write,
   input  logic [OUT_W*RATIO-1:0] d_in,
   input  logic                   read,
   output logic [OUT_W-1:0]       d_out,
   output logic                   full,
   output logic                   empty,
   output logic                   wr_room,
   output logic [DEPTH_LOG2:0]    data_count,
   output logic                   wr_ack,
   output logic                   wr_err,
   output logic                   rd_ack,
   output logic                   rd_err
);

   localparam int IN_W  = OUT_W * RATIO;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;

   localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(DEPTH - RATIO);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] RATIO_CNT  = CNT_W'(RATIO);
   localparam logic [PTR_W-1:0] TAIL_STEP  = PTR_W'(RATIO);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [OUT_W-1:0] lanes [RATIO];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             wr_ok;
   logic             rd_ok;

   // Lane 0 is always the word the consumer sees first, so the storage loop stays order-agnostic.
   for (genvar i = 0; i < RATIO; i++) begin : g_lane
      if (MSB_FIRST != 0) begin : g_msb
         assign lanes[i] = d_in[IN_W-1-i*OUT_W -: OUT_W];
      end else begin : g_lsb
         assign lanes[i] = d_in[i*OUT_W +: OUT_W];
      end
   end

   // Both requests are judged against the count before the edge, so a write into an empty FIFO cannot feed a same-cycle read.
   assign wr_ok      = write & ~flush & (count <= ROOM_LIMIT);
   assign rd_ok      = read & ~flush & (count != '0);
   assign count_next = count + (wr_ok ? RATIO_CNT : '0) - {{DEPTH_LOG2{1'b0}}, rd_ok};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
         rd_ack <= 1'b0;
         rd_err <= 1'b0;
      end else if (flush) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
         rd_ack <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         if (wr_ok) tail <= tail + TAIL_STEP;
         if (rd_ok) head <= head + PTR_W'(1);
         count  <= count_next;
         wr_ack <= wr_ok;
         wr_err <= write & ~wr_ok;
         rd_ack <= rd_ok;
         rd_err <= read & ~rd_ok;
      end
   end

   // Storage is deliberately left out of reset; it is only observable once count says it is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int i = 0; i < RATIO; i++) begin
            mem[tail + PTR_W'(i)] <= lanes[i];
         end
      end
   end

   assign d_out      = mem[head];
   assign data_count = count;
   assign full       = (count == FULL_COUNT);
   assign empty      = (count == '0);
   assign wr_room    = (count <= ROOM_LIMIT);

endmodule

// File: tb/tb_fifo_width_down_conv.sv
// Bench for fifo_width_down_conv: two instances (MSB-first and LSB-first) share stimulus and are
// compared against a queue-based model of the FIFO contents.
module tb_fifo_width_down_conv;

   localparam int OUT_W = 16;
   localparam int RATIO = 2;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] d_in = '0;

   logic [15:0] m_d_out, l_d_out;
   logic        m_full, m_empty, m_wr_room, m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;
   logic        l_full, l_empty, l_wr_room, l_wr_ack, l_wr_err, l_rd_ack, l_rd_err;
   logic [4:0]  m_data_count, l_data_count;

   int checks = 0;
   int failures = 0;

   logic [15:0] q_m[$];
   logic [15:0] q_l[$];
   logic        exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err;

   always #5 clk = ~clk;

   fifo_width_down_conv #(.OUT_W(16), .RATIO(2), .DEPTH_LOG2(4), .MSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .d_in(d_in), .read(read),
      .d_out(m_d_out), .full(m_full), .empty(m_empty), .wr_room(m_wr_room),
      .data_count(m_data_count), .wr_ack(m_wr_ack), .wr_err(m_wr_err),
      .rd_ack(m_rd_ack), .rd_err(m_rd_err));

   fifo_width_down_conv #(.OUT_W(16), .RATIO(2), .DEPTH_LOG2(4), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .d_in(d_in), .read(read),
      .d_out(l_d_out), .full(l_full), .empty(l_empty), .wr_room(l_wr_room),
      .data_count(l_data_count), .wr_ack(l_wr_ack), .wr_err(l_wr_err),
      .rd_ack(l_rd_ack), .rd_err(l_rd_err));

   // Drive one clock of requests and advance the model; returns 1 time unit after the edge.
   task automatic step(input logic w, input logic r, input logic f, input logic [31:0] d);
      bit wok, rok;
      write = w; read = r; flush = f; d_in = d;
      wok = w && !f && (q_m.size() <= DEPTH - RATIO);
      rok = r && !f && (q_m.size() >= 1);
      @(posedge clk);
      if (f) begin
         q_m.delete(); q_l.delete();
      end else begin
         if (rok) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
         end
         if (wok) begin
            q_m.push_back(d[31:16]); q_m.push_back(d[15:0]);
            q_l.push_back(d[15:0]);  q_l.push_back(d[31:16]);
         end
      end
      exp_wr_ack = wok;
      exp_wr_err = w && !f && !wok;
      exp_rd_ack = rok;
      exp_rd_err = r && !f && !rok;
      #1;
      write = 1'b0; read = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (m_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", m_empty); end
      checks++; if (m_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", m_full); end
      checks++; if (m_wr_room !== 1'b1) begin failures++; $display("[TB] FAIL reset_wr_room got=%b exp=1", m_wr_room); end
      checks++; if (m_data_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", m_data_count); end
      checks++; if ({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} !== 4'b0) begin
         failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      step(1'b1, 1'b0, 1'b0, 32'hAAAA_5555);
      checks++; if (m_wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack got=%b exp=1", m_wr_ack); end
      checks++; if (m_data_count !== 5'd2) begin failures++; $display("[TB] FAIL wr_count got=%0d exp=2", m_data_count); end
      checks++; if (m_d_out !== 16'hAAAA) begin failures++; $display("[TB] FAIL msb_first_word got=%h exp=aaaa", m_d_out); end
      checks++; if (l_d_out !== 16'h5555) begin failures++; $display("[TB] FAIL lsb_first_word got=%h exp=5555", l_d_out); end
      step(1'b0, 1'b1, 1'b0, 32'h0);
      checks++; if (m_rd_ack !== 1'b1) begin failures++; $display("[TB] FAIL rd_ack got=%b exp=1", m_rd_ack); end
      checks++; if (m_d_out !== 16'h5555) begin failures++; $display("[TB] FAIL msb_second_word got=%h exp=5555", m_d_out); end
      checks++; if (l_d_out !== 16'hAAAA) begin failures++; $display("[TB] FAIL lsb_second_word got=%h exp=aaaa", l_d_out); end
      checks++; if (m_data_count !== 5'd1) begin failures++; $display("[TB] FAIL rd_count got=%0d exp=1", m_data_count); end
      step(1'b0, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      checks++; if (m_data_count !== 5'd16) begin failures++; $display("[TB] FAIL full_count got=%0d exp=16", m_data_count); end
      checks++; if (m_full !== 1'b1) begin failures++; $display("[TB] FAIL full_flag got=%b exp=1", m_full); end
      checks++; if (m_wr_room !== 1'b0) begin failures++; $display("[TB] FAIL full_wr_room got=%b exp=0", m_wr_room); end
      checks++; if (m_d_out !== q_m[0]) begin failures++; $display("[TB] FAIL full_head got=%h exp=%h", m_d_out, q_m[0]); end
      step(1'b1, 1'b0, 1'b0, $urandom);
      checks++; if ({m_wr_ack, m_wr_err} !== 2'b01) begin failures++; $display("[TB] FAIL overflow_flags got=%b exp=01", {m_wr_ack, m_wr_err}); end
      checks++; if (m_data_count !== 5'd16) begin failures++; $display("[TB] FAIL overflow_count got=%0d exp=16", m_data_count); end
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, $urandom);
      checks++; if ({m_wr_ack, m_wr_err} !== 2'b01) begin failures++; $display("[TB] FAIL room15_flags got=%b exp=01", {m_wr_ack, m_wr_err}); end
      checks++; if (m_data_count !== 5'd15) begin failures++; $display("[TB] FAIL room15_count got=%0d exp=15", m_data_count); end
      checks++; if (l_d_out !== q_l[0]) begin failures++; $display("[TB] FAIL room15_lsb_head got=%h exp=%h", l_d_out, q_l[0]); end
      step(1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic test_read_empty();
      step(1'b0, 1'b1, 1'b0, 32'h0);
      checks++; if ({m_rd_ack, m_rd_err} !== 2'b01) begin failures++; $display("[TB] FAIL underflow_flags got=%b exp=01", {m_rd_ack, m_rd_err}); end
      checks++; if (m_data_count !== 5'd0) begin failures++; $display("[TB] FAIL underflow_count got=%0d exp=0", m_data_count); end
      step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
      checks++; if ({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} !== 4'b1001) begin
         failures++; $display("[TB] FAIL rw_empty_flags got=%b exp=1001", {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err}); end
      checks++; if (m_data_count !== 5'd2) begin failures++; $display("[TB] FAIL rw_empty_count got=%0d exp=2", m_data_count); end
      checks++; if (m_d_out !== 16'h1234) begin failures++; $display("[TB] FAIL rw_empty_head got=%h exp=1234", m_d_out); end
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      step(1'b1, 1'b1, 1'b0, $urandom);
      checks++; if ({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} !== 4'b1010) begin
         failures++; $display("[TB] FAIL rw14_flags got=%b exp=1010", {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err}); end
      checks++; if (m_data_count !== 5'd15) begin failures++; $display("[TB] FAIL rw14_count got=%0d exp=15", m_data_count); end
      checks++; if (m_d_out !== q_m[0]) begin failures++; $display("[TB] FAIL rw14_head got=%h exp=%h", m_d_out, q_m[0]); end
      step(1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 55, 1'b0, $urandom);
         checks++; if (m_data_count !== 5'(q_m.size())) begin
            failures++; $display("[TB] FAIL rand_count op=%0d got=%0d exp=%0d", n, m_data_count, q_m.size()); end
         checks++; if ({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} !== {exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err}) begin
            failures++; $display("[TB] FAIL rand_flags op=%0d got=%b exp=%b", n, {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err},
                                 {exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err}); end
         checks++; if ({m_full, m_empty, m_wr_room} !== {q_m.size() == DEPTH, q_m.size() == 0, q_m.size() <= DEPTH - RATIO}) begin
            failures++; $display("[TB] FAIL rand_status op=%0d got=%b size=%0d", n, {m_full, m_empty, m_wr_room}, q_m.size()); end
         if (q_m.size() > 0) begin
            checks++; if (m_d_out !== q_m[0]) begin failures++; $display("[TB] FAIL rand_msb_data op=%0d got=%h exp=%h", n, m_d_out, q_m[0]); end
            checks++; if (l_d_out !== q_l[0]) begin failures++; $display("[TB] FAIL rand_lsb_data op=%0d got=%h exp=%h", n, l_d_out, q_l[0]); end
         end
      end
      step(1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic test_flush_and_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      checks++; if (m_data_count !== 5'd6) begin failures++; $display("[TB] FAIL pre_flush_count got=%0d exp=6", m_data_count); end
      step(1'b1, 1'b1, 1'b1, $urandom);
      checks++; if (m_data_count !== 5'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", m_data_count); end
      checks++; if (m_empty !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty got=%b exp=1", m_empty); end
      checks++; if ({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} !== 4'b0) begin
         failures++; $display("[TB] FAIL flush_flags got=%b exp=0000", {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err}); end
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, $urandom);
      @(negedge clk);
      write = 1'b1; read = 1'b1; d_in = $urandom;
      rst_n = 1'b0;
      #1;
      checks++; if (m_data_count !== 5'd0) begin failures++; $display("[TB] FAIL async_rst_count got=%0d exp=0", m_data_count); end
      checks++; if ({m_full, m_empty, m_wr_room} !== 3'b011) begin failures++; $display("[TB] FAIL async_rst_status got=%b exp=011", {m_full, m_empty, m_wr_room}); end
      checks++; if ({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} !== 4'b0) begin
         failures++; $display("[TB] FAIL async_rst_flags got=%b exp=0000", {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err}); end
      @(negedge clk);
      write = 1'b0; read = 1'b0;
      rst_n = 1'b1;
      q_m.delete(); q_l.delete();
      step(1'b1, 1'b0, 1'b0, 32'hBEEF_CAFE);
      checks++; if (m_d_out !== 16'hBEEF || m_data_count !== 5'd2) begin
         failures++; $display("[TB] FAIL post_rst_write got=%h/%0d exp=beef/2", m_d_out, m_data_count); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_full();
      test_read_empty();
      test_random();
      test_flush_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
